// File: rtl/apu_pkg.sv
// Shared APU definitions: frame sequencer defaults, mode encoding and
// the debug view of the frame counter state.
package apu_pkg;

  // Clocks per sequencer step, about 240 Hz from a 1.79 MHz system clock.
  localparam int unsigned FRAME_DIVIDER_DEFAULT = 7457;

  // Sequence length of each frame mode.
  localparam logic [2:0] FRAME_STEPS_4 = 3'd4;
  localparam logic [2:0] FRAME_STEPS_5 = 3'd5;

  // Encoding matches bit 7 of the $4017 write.
  typedef enum logic {
    FRAME_4STEP = 1'b0,
    FRAME_5STEP = 1'b1
  } frame_mode_e;

  // Internal state of the frame counter, exported for observation.
  typedef struct packed {
    frame_mode_e mode;
    logic        inhibit;
    logic [2:0]  step;
    logic [15:0] prescaler;
  } frame_dbg_t;

  // Index of the final step of the sequence in the given mode.
  function automatic logic [2:0] frame_last_step(frame_mode_e mode);
    return (mode == FRAME_5STEP) ? (FRAME_STEPS_5 - 3'd1)
                                 : (FRAME_STEPS_4 - 3'd1);
  endfunction

endpackage

// File: rtl/frame_counter_if.sv
// Frame counter bus: CPU-side register access in, channel clock enables
// and frame IRQ out.
//
// Signalling: there is no valid/ready backpressure on this bus. reg_event
// and status_read are single-cycle strobes qualified by nothing else and
// always accepted in the cycle they are high; reg_4017 is only meaningful
// while reg_event is high. enable_240hz and enable_120hz are single-cycle
// strobes the channels must consume in the cycle they appear. irq_flag is
// a level that stays high until cleared.
interface frame_counter_if;
  logic [7:0] reg_4017;
  logic       reg_event;
  logic       status_read;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       irq_flag;

  // CPU / register-decode side.
  modport master (
    output reg_4017,
    output reg_event,
    output status_read,
    input  enable_240hz,
    input  enable_120hz,
    input  irq_flag
  );

  // Frame counter side.
  modport slave (
    input  reg_4017,
    input  reg_event,
    input  status_read,
    output enable_240hz,
    output enable_120hz,
    output irq_flag
  );
endinterface

// File: rtl/frame_counter_strobe_divider.sv
// Modulo-DIVIDER prescaler. tick is high combinationally while the count
// sits at DIVIDER-1; the count wraps to 0 on that same edge.
module strobe_divider
  import apu_pkg::*;
#(
  parameter int unsigned DIVIDER = FRAME_DIVIDER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  output logic        tick,
  output logic [15:0] count
);

  localparam logic [15:0] LAST = 16'(DIVIDER - 1);

  logic [15:0] count_q;

  assign tick  = (count_q == LAST);
  assign count = count_q;

  // Count up every clock, wrap at DIVIDER-1, restart on clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= 16'd0;
    end else if (tick) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/frame_counter.sv
// APU frame sequencer: turns prescaler ticks into quarter/half-frame
// strobes in 4-step or 5-step mode and manages the frame IRQ.
module frame_counter
  import apu_pkg::*;
#(
  parameter int unsigned DIVIDER = FRAME_DIVIDER_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_counter_if.slave        bus,
  output frame_dbg_t            dbg
);

  logic        tick;
  logic [15:0] prescaler;

  frame_mode_e mode_q,    mode_d;
  logic        inhibit_q, inhibit_d;
  logic [2:0]  step_q,    step_d;

  logic        q240_q, q240_d;
  logic        h120_q, h120_d;
  logic        irq_q,  irq_d;

  // Only the mode and inhibit bits of $4017 belong to this block.
  logic unused_reg_bits;
  assign unused_reg_bits = ^bus.reg_4017[5:0];

  // A register write restarts the prescaler; any tick on that edge is lost.
  strobe_divider #(
    .DIVIDER (DIVIDER)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.reg_event),
    .tick  (tick),
    .count (prescaler)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= FRAME_4STEP;
      inhibit_q <= 1'b0;
      step_q    <= 3'd0;
    end else begin
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      step_q    <= step_d;
    end
  end

  // Next sequencer state: a write restarts at step 0, a tick advances.
  always_comb begin
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    step_d    = step_q;
    if (bus.reg_event) begin
      mode_d    = frame_mode_e'(bus.reg_4017[7]);
      inhibit_d = bus.reg_4017[6];
      step_d    = 3'd0;
    end else if (tick) begin
      step_d = (step_q == frame_last_step(mode_q)) ? 3'd0 : step_q + 3'd1;
    end
  end

  // Strobe and IRQ decode for the current edge.
  always_comb begin
    q240_d = 1'b0;
    h120_d = 1'b0;
    irq_d  = irq_q;
    if (bus.reg_event) begin
      // Entering 5-step mode clocks the units once straight away.
      q240_d = bus.reg_4017[7];
      h120_d = bus.reg_4017[7];
      if (bus.reg_4017[6]) begin
        irq_d = 1'b0;
      end else if (bus.status_read) begin
        irq_d = 1'b0;
      end
    end else begin
      if (tick) begin
        if (mode_q == FRAME_4STEP) begin
          q240_d = 1'b1;
          h120_d = (step_q == 3'd1) || (step_q == 3'd3);
        end else begin
          q240_d = (step_q != 3'd3);
          h120_d = (step_q == 3'd1) || (step_q == 3'd4);
        end
      end
      // Setting the IRQ beats a status read on the same edge.
      if (tick && (mode_q == FRAME_4STEP) && (step_q == 3'd3) && !inhibit_q) begin
        irq_d = 1'b1;
      end else if (bus.status_read) begin
        irq_d = 1'b0;
      end
    end
  end

  // Registered outputs so each strobe lasts exactly one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      q240_q <= 1'b0;
      h120_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      q240_q <= q240_d;
      h120_q <= h120_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.enable_240hz = q240_q;
  assign bus.enable_120hz = h120_q;
  assign bus.irq_flag     = irq_q;

  assign dbg.mode      = mode_q;
  assign dbg.inhibit   = inhibit_q;
  assign dbg.step      = step_q;
  assign dbg.prescaler = prescaler;

endmodule
